rename_free_list: RTL
=====================

Name: rename_free_list

Overview:
- N-wide physical-register free list for the rename stage of the out-of-order core.
- Circular queue of free physical register numbers:
  - rename allocates up to WIDTH registers per cycle from the speculative head;
  - commit returns up to WIDTH stale registers per cycle at the tail;
  - a separate retire head tracks committed allocations, so a pipeline flush recovers exactly the speculatively allocated registers.

Parameters:
- NUM_PREGS, 64, total physical registers; power of two.
- NUM_AREGS, 32, architectural registers; pregs 0..NUM_AREGS-1 are architecturally mapped at reset.
- WIDTH, 2, allocate, free and commit lanes per cycle; 1..4.
- NUM_CKPT, 4, branch checkpoint slots (used only with the optional feature).
- DEPTH, NUM_PREGS-NUM_AREGS, derived: queue entries; power of two.
- PREG_W, $clog2(NUM_PREGS), derived.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high.
- alloc_req  in  WIDTH  per-lane allocation request; set bits contiguous from lane 0.
- alloc_ok  out  1  request granted this cycle; all-or-nothing.
- alloc_preg  out  WIDTH*PREG_W  lane k gets the entry at head+k; valid when alloc_ok.
- free_valid  in  WIDTH  per-lane free from commit.
- free_preg  in  WIDTH*PREG_W  register returned per lane.
- commit_cnt  in  $clog2(WIDTH+1)  allocations made permanent this cycle.
- flush  in  1  full pipeline flush.
- ckpt_save  in  1  save a checkpoint.
- ckpt_restore  in  1  restore a checkpoint.
- ckpt_id  in  $clog2(NUM_CKPT)  checkpoint slot.
- free_count  out  $clog2(DEPTH)+1  number of free entries (tail-head).
- err_overflow  out  1  sticky error flag.

Behaviour:
- Pointers are spec_head, retire_head and tail, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty: spec_head==tail.
  - Full: low bits equal and wrap bits differ.
- Reset:
  - entry i = NUM_AREGS+i;
  - spec_head = retire_head = 0;
  - tail = DEPTH (full);
  - alloc_ok = 0, alloc_preg = 0, err_overflow = 0, free_count = DEPTH.
  - rst mid-operation discards everything, including checkpoints.
- Allocate (combinational output):
  - n = popcount(alloc_req).
  - alloc_ok = (n>0) && (free_count >= n) && !flush && !rst.
  - Lanes k<n drive entry[spec_head+k]; other lanes drive 0.
  - On alloc_ok, spec_head += n at the clock edge. If not granted, nothing is consumed and the requester retries.
- Free:
  - Valid lanes whose preg != 0 are compacted in lane order and written at tail, tail+1, ...
  - tail advances by the count of written lanes.
  - Registers freed in a cycle are not allocatable until the next cycle; there is no bypass.
- Commit: retire_head += commit_cnt. commit_cnt must not exceed spec_head-retire_head.
- Flush:
  - spec_head <= retire_head + commit_cnt of the same cycle.
  - Frees and commits in the flush cycle are still applied.
  - Flush suppresses allocation that cycle.
- Overflow: if the written lanes would exceed DEPTH entries, the write is dropped and err_overflow is set sticky until rst.
- Arithmetic: all pointer math is modulo 2*DEPTH; the array is indexed by the low $clog2(DEPTH) bits.
- Priority order: rst > flush > ckpt_restore > alloc.

Optional Feature:
- Macro FREELIST_CKPT_EN.
- Defined:
  - ckpt_save stores the post-allocation spec_head (including this cycle's grant) in slot ckpt_id.
  - ckpt_restore sets spec_head <= slot[ckpt_id] and suppresses allocation that cycle.
  - Frees and commits are still applied in the restore cycle.
  - Save and restore in the same cycle: restore wins and the save is ignored.
- Undefined: ckpt_* inputs are ignored and no slot storage is built.

Test Plan:
- Reset, then alloc_req=2'b11 for 16 consecutive cycles:
  - grants pregs 32,33 / 34,35 / ... / 62,63;
  - on the next request alloc_ok=0 and free_count=0.
- free_count=1, alloc_req=2'b11 -> alloc_ok=0 and spec_head unchanged; alloc_req=2'b01 -> grants the single entry.
- free_valid=2'b11 with free_preg={0,40} -> only 40 is written; tail+=1; free_count increments by 1.
- Allocate 6 pregs, commit_cnt=2, then flush -> free_count returns to DEPTH-2 and the next allocation returns the 3rd allocated preg.
- Full list, free of preg 5 -> write dropped; err_overflow=1 and stays 1 until rst.
- With FREELIST_CKPT_EN:
  - save slot 1 after allocating 34,35, allocate 4 more, restore slot 1 -> next grant is 36,37;
  - restore in the same cycle as alloc_req -> alloc_ok=0.

Source files
------------

// File: rtl/rename_free_list.sv
// Rename-stage physical register free list: circular queue with speculative head,
// retire head and tail. Optional branch checkpoints are built under `FREELIST_CKPT_EN.
module rename_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int WIDTH     = 2,
  parameter int NUM_CKPT  = 4,
  localparam int DEPTH    = NUM_PREGS - NUM_AREGS,
  localparam int PREG_W   = $clog2(NUM_PREGS),
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int PTR_W    = IDX_W + 1,
  localparam int CNT_W    = $clog2(WIDTH + 1),
  localparam int CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          alloc_req_i,
  output logic                      alloc_ok_o,
  output logic [WIDTH*PREG_W-1:0]   alloc_preg_o,
  input  logic [WIDTH-1:0]          free_valid_i,
  input  logic [WIDTH*PREG_W-1:0]   free_preg_i,
  input  logic [CNT_W-1:0]          commit_cnt_i,
  input  logic                      flush_i,
  input  logic                      ckpt_save_i,
  input  logic                      ckpt_restore_i,
  input  logic [CKPT_W-1:0]         ckpt_id_i,
  output logic [PTR_W-1:0]          free_count_o,
  output logic                      err_overflow_o
);

  logic [PREG_W-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0]  spec_head_q, spec_head_d;
  logic [PTR_W-1:0]  retire_head_q, retire_head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  n_req;
  logic [PTR_W-1:0]  free_count;
  logic              alloc_ok;
  logic              restore;
  logic [PTR_W-1:0]  ckpt_target;

  logic [WIDTH-1:0]  wr_qual;
  logic [CNT_W-1:0]  wr_off [WIDTH];
  logic [CNT_W-1:0]  wr_cnt;
  logic [PTR_W-1:0]  occupancy;
  logic              wr_ovf;

  always_comb begin
    n_req = '0;
    for (int k = 0; k < WIDTH; k++) n_req = n_req + CNT_W'(alloc_req_i[k]);
    free_count = tail_q - spec_head_q;
    alloc_ok   = (n_req != '0) && (free_count >= PTR_W'(n_req)) && !flush_i && !rst && !restore;
    alloc_preg_o = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (alloc_ok && (CNT_W'(k) < n_req))
        alloc_preg_o[k*PREG_W +: PREG_W] = entries_q[spec_head_q[IDX_W-1:0] + IDX_W'(k)];
    end
  end

  // Lanes returning preg 0 are skipped; the rest are packed in lane order at the tail.
  always_comb begin
    wr_cnt = '0;
    for (int k = 0; k < WIDTH; k++) begin
      wr_qual[k] = free_valid_i[k] && (free_preg_i[k*PREG_W +: PREG_W] != '0);
      wr_off[k]  = wr_cnt;
      wr_cnt     = wr_cnt + CNT_W'(wr_qual[k]);
    end
  end

  // Entries between the retire head and the tail are live (free or recoverable),
  // so that span, after this cycle's commits, bounds what the tail may write.
  always_comb begin
    retire_head_d = retire_head_q + PTR_W'(commit_cnt_i);
    occupancy     = tail_q - retire_head_d;
    wr_ovf        = ((PTR_W+1)'(occupancy) + (PTR_W+1)'(wr_cnt)) > (PTR_W+1)'(DEPTH);
    tail_d        = wr_ovf ? tail_q : tail_q + PTR_W'(wr_cnt);
    err_d         = err_q | wr_ovf;
    if (flush_i)       spec_head_d = retire_head_d;
    else if (restore)  spec_head_d = ckpt_target;
    else if (alloc_ok) spec_head_d = spec_head_q + PTR_W'(n_req);
    else               spec_head_d = spec_head_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head_q   <= '0;
      retire_head_q <= '0;
      tail_q        <= PTR_W'(DEPTH);
      err_q         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= PREG_W'(NUM_AREGS + i);
    end else begin
      spec_head_q   <= spec_head_d;
      retire_head_q <= retire_head_d;
      tail_q        <= tail_d;
      err_q         <= err_d;
      for (int k = 0; k < WIDTH; k++) begin
        if (wr_qual[k] && !wr_ovf)
          entries_q[tail_q[IDX_W-1:0] + IDX_W'(wr_off[k])] <= free_preg_i[k*PREG_W +: PREG_W];
      end
    end
  end

`ifdef FREELIST_CKPT_EN
  logic [PTR_W-1:0] ckpt_q [NUM_CKPT];

  assign restore     = ckpt_restore_i;
  assign ckpt_target = ckpt_q[ckpt_id_i];

  // Saved value includes this cycle's grant; a same-cycle restore takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CKPT; i++) ckpt_q[i] <= '0;
    end else if (ckpt_save_i && !ckpt_restore_i) begin
      ckpt_q[ckpt_id_i] <= spec_head_d;
    end
  end
`else
  logic unused_ckpt;

  assign restore     = 1'b0;
  assign ckpt_target = '0;
  assign unused_ckpt = ^{ckpt_save_i, ckpt_restore_i, ckpt_id_i};
`endif

  assign alloc_ok_o     = alloc_ok;
  assign free_count_o   = free_count;
  assign err_overflow_o = err_q;

endmodule
